// File: rtl/f_to_f_sched.sv
// rtl/f_to_f_sched.sv - one-job-at-a-time scheduler for the float/fixed converter units
// Optional WAIT timeout abort is compiled in with F2F_SCHED_TIMEOUT_EN.
module f_to_f_sched #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [47:0] datain,
    input  logic        empty,
    output logic        rden,
    output logic [5:0]  unit_en,
    output logic [79:0] operand,
    input  logic [5:0]  done,
    input  logic [79:0] result,
    input  logic        full,
    output logic [47:0] dataout,
    output logic        wren,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OP0  = 3'd1;
    localparam logic [2:0] S_OP1  = 3'd2;
    localparam logic [2:0] S_FIRE = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_OUT0 = 3'd5;
    localparam logic [2:0] S_OUT1 = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic [79:0] operand_q, operand_d;
    logic [79:0] res_q, res_d;
    logic [1:0]  status_q, status_d;
    logic [47:0] dataout_q, dataout_d;

    logic [2:0]  hdr_sel;
    logic        hdr_valid;
    logic        done_sel;
    logic        timeout_hit;

    // Header {app, size} -> converter unit index
    always_comb begin
        hdr_sel   = 3'd0;
        hdr_valid = 1'b1;
        case (datain[47:43])
            5'b00_001: hdr_sel = 3'd0;
            5'b00_010: hdr_sel = 3'd1;
            5'b00_011: hdr_sel = 3'd5;
            5'b01_001: hdr_sel = 3'd2;
            5'b01_010: hdr_sel = 3'd3;
            5'b01_011: hdr_sel = 3'd4;
            default:   hdr_valid = 1'b0;
        endcase
    end

    assign done_sel = (state_q == S_WAIT) && done[sel_q];

`ifdef F2F_SCHED_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_FIRE) begin
            cnt_d = 16'd0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        operand_d = operand_q;
        res_d     = res_q;
        status_d  = status_q;
        dataout_d = dataout_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    sel_d   = hdr_sel;
                    valid_d = hdr_valid;
                    state_d = S_OP0;
                end
            end
            S_OP0: begin
                if (!empty) begin
                    operand_d[79:32] = datain;
                    state_d          = S_OP1;
                end
            end
            S_OP1: begin
                if (!empty) begin
                    operand_d[31:0] = datain[47:16];
                    state_d         = S_FIRE;
                end
            end
            S_FIRE: begin
                if (valid_q) begin
                    state_d = S_WAIT;
                end else begin
                    res_d     = 80'd0;
                    status_d  = 2'b10;
                    dataout_d = 48'd0;
                    state_d   = S_OUT0;
                end
            end
            S_WAIT: begin
                // done has priority over an abort landing in the same cycle
                if (done_sel) begin
                    res_d     = result;
                    status_d  = 2'b00;
                    dataout_d = result[79:32];
                    state_d   = S_OUT0;
                end else if (timeout_hit) begin
                    res_d     = 80'd0;
                    status_d  = 2'b01;
                    dataout_d = 48'd0;
                    state_d   = S_OUT0;
                end
            end
            S_OUT0: begin
                if (!full) begin
                    dataout_d = {res_q[31:0], 14'd0, status_q};
                    state_d   = S_OUT1;
                end
            end
            S_OUT1: begin
                if (!full) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            sel_q     <= 3'd0;
            valid_q   <= 1'b0;
            operand_q <= 80'd0;
            res_q     <= 80'd0;
            status_q  <= 2'b00;
            dataout_q <= 48'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            operand_q <= operand_d;
            res_q     <= res_d;
            status_q  <= status_d;
            dataout_q <= dataout_d;
        end
    end

    // rden gated by rstn so nothing is popped while reset holds the FSM in IDLE
    assign rden    = rstn && !empty &&
                     ((state_q == S_IDLE) || (state_q == S_OP0) || (state_q == S_OP1));
    assign wren    = !full && ((state_q == S_OUT0) || (state_q == S_OUT1));
    assign unit_en = ((state_q == S_FIRE) && valid_q) ? 6'(6'b000001 << sel_q) : 6'b000000;
    assign operand = operand_q;
    assign dataout = dataout_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/f_to_f_sched.md
# f_to_f_sched

Job scheduler for the float/fixed conversion datapath. Pops command words from a first-word-fall-through input FIFO and assembles an 80-bit operand. Fires exactly one of the six converter units with a single-cycle enable, then waits for that unit's done, with an optional timeout. Finally pushes a two-word result/status record into the output FIFO. One job is in flight at a time; the block replaces free-running enable generation in front of the converter units.

## Interface
- TIMEOUT_CYC, 64: cycles allowed between enable pulse and done before abort (2..65535)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- datain  in  48  input FIFO head word (valid whenever empty=0)
- empty  in  1  input FIFO empty
- rden  out  1  pop input FIFO head this cycle
- unit_en  out  6  one-hot converter enable pulse; bit k drives clk_en_(k+1)
- operand  out  80  registered operand; float_in=operand, int_in=operand[79:40], frec_in=operand[39:0]
- done  in  6  converter done pulses, bit k = done_(k+1)
- result  in  80  result of the currently selected unit, muxed by datapath, valid in done cycle
- full  in  1  output FIFO full
- dataout  out  48  result word
- wren  out  1  push dataout
- busy  out  1  high in any state except IDLE

## Operation
- Header word: datain[47:46]=app, datain[45:43]=size, remainder ignored.
- Always followed by two payload words: operand = {w1[47:0], w2[47:16]}.
- Unit map (bit index of unit_en):
  - app=0: size=1 → 0, size=2 → 1, size=3 → 5
  - app=1: size=1 → 2, size=2 → 3, size=3 → 4
  - any other app/size → invalid
- States:
  - IDLE: if !empty, pop header and latch it → OP0
  - OP0: if !empty, pop into operand[79:32] → OP1
  - OP1: if !empty, pop into operand[31:0] → FIRE
  - FIRE: if valid, pulse unit_en[sel] for one cycle → WAIT; if invalid, status=2'b10, res=0 → OUT0 (no unit fired)
  - WAIT: on done[sel], latch result with status=00 → OUT0; on timeout, res=0, status=2'b01 → OUT0; done bits other than sel are ignored
  - OUT0: if !full, wren=1, dataout=res[79:32] → OUT1
  - OUT1: if !full, wren=1, dataout={res[31:0], 14'b0, status} → IDLE
- rden = 1 only in IDLE/OP0/OP1 with empty=0; never popped while empty.
- wren = 1 only in OUT0/OUT1 with full=0.

## Timing
- Reset values: rden=0, unit_en=0, operand=0, dataout=0, wren=0, busy=0, state=IDLE, timeout counter=0.
- rden, wren, unit_en are combinational from state and empty/full; operand, dataout, result and status are registered.
- Best case with FIFO never empty, unit done D cycles after the enable pulse:
  - header pop at cycle 0; unit_en pulse at cycle 3
  - first wren at cycle 4+D; second wren at cycle 5+D
  - next header pop at cycle 6+D
- done in the same cycle as the unit_en pulse is ignored; done is sampled from the cycle after.
- Timeout counter: cleared on entry to WAIT, incremented each WAIT cycle. Abort when count==TIMEOUT_CYC-1 with no done. If done and the last count arrive together, done wins.
- A late done arriving after abort, or in any state other than WAIT, is discarded.
- empty high in OP0/OP1 stalls that state indefinitely with no pop.
- full high stalls OUT0/OUT1 with dataout held stable.
- rstn low mid-job: immediate return to IDLE with reset values; the partial job is lost; no enable pulse emitted.

## Configuration
- F2F_SCHED_TIMEOUT_EN defined: WAIT timeout as above; status 2'b01 is possible.
- F2F_SCHED_TIMEOUT_EN not defined: no counter logic; WAIT holds until done[sel] forever; status is 2'b00 or 2'b10 only.

## Test plan
- Header app=0,size=1 plus payload 0x123456789ABC and 0xDEF0_1234_5678, done[0] 5 cycles after the pulse with result=0x1111...:
  - unit_en=6'b000001 for exactly 1 cycle; operand=0x123456789ABC_DEF01234
  - dataout 0x111111111111 then 0x111111110000; wren exactly 2 cycles
- Each of the six valid app/size pairs: the single correct unit_en bit pulses; all other bits stay 0.
- app=2,size=1: no unit_en pulse; output words 0x000000000000 and 0x000000000002.
- Timeout enabled, TIMEOUT_CYC=8, no done:
  - second output word low bits = 01, 8 cycles after the pulse
  - a done[0] injected 2 cycles later produces no extra wren.
- empty toggling between payload words, plus full=1 for 10 cycles in OUT0:
  - no pop while empty
  - dataout held stable while full
  - exactly 3 pops and 2 pushes per job
- rstn low for 1 cycle during WAIT:
  - all outputs return to 0 and busy=0
  - the next job completes normally.
